// File: rtl/cdb_arbiter.sv
// cdb_arbiter: round-robin N-to-1 result arbiter driving one registered CDB slot.
// Define CDB_ARB_SPEC_SQUASH_EN to squash speculative results on a mispredicted branch.
module cdb_arbiter #(
  parameter int N       = 4,
  parameter int BW_TAG  = 6,
  parameter int BW_DATA = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N-1:0]         i_valid,
  output logic [N-1:0]         i_ready,
  input  logic [N*BW_TAG-1:0]  i_tag,
  input  logic [N*BW_DATA-1:0] i_data,
  input  logic [N-1:0]         i_spec,
  output logic                 o_valid,
  input  logic                 o_ready,
  output logic [BW_TAG-1:0]    o_tag,
  output logic [BW_DATA-1:0]   o_data,
  output logic [N-1:0]         o_src,
  input  logic                 i_branch_valid,
  input  logic                 i_branch_correct_prediction
);
  localparam int PW = $clog2(N);

  logic               r_valid;
  logic [BW_TAG-1:0]  r_tag;
  logic [BW_DATA-1:0] r_data;
  logic [N-1:0]       r_src;
  logic [PW-1:0]      r_ptr;
  logic [N-1:0]       w_elig;
  logic [N-1:0]       w_grant;
  logic [PW-1:0]      w_gidx;
  logic [PW-1:0]      w_k;
  logic               w_found;
  logic               w_load;
  logic [BW_TAG-1:0]  w_tag;
  logic [BW_DATA-1:0] w_data;

`ifdef CDB_ARB_SPEC_SQUASH_EN
  logic r_spec;
  logic w_flush;
  assign w_flush = i_branch_valid && !i_branch_correct_prediction;
  assign w_elig  = i_valid & ~({N{w_flush}} & i_spec);
  assign o_valid = r_valid && !(w_flush && r_spec);
`else
  logic w_unused;
  assign w_unused = ^{i_spec, i_branch_valid, i_branch_correct_prediction};
  assign w_elig   = i_valid;
  assign o_valid  = r_valid;
`endif

  assign w_load  = !o_valid || o_ready;
  assign w_grant = w_found ? (N'(1) << w_gidx) : '0;
  assign i_ready = w_grant & {N{w_load}};
  assign o_tag   = r_tag;
  assign o_data  = r_data;
  assign o_src   = r_src;

  // Cyclic priority search starting at the round-robin pointer.
  always_comb begin
    w_found = 1'b0;
    w_gidx  = '0;
    w_k     = '0;
    for (int i = 0; i < N; i++) begin
      w_k = PW'((int'(r_ptr) + i) % N);
      if (!w_found && w_elig[w_k]) begin
        w_found = 1'b1;
        w_gidx  = w_k;
      end
    end
  end

  always_comb begin
    w_tag  = '0;
    w_data = '0;
    for (int i = 0; i < N; i++) begin
      w_tag  = w_grant[i] ? i_tag[i*BW_TAG +: BW_TAG] : w_tag;
      w_data = w_grant[i] ? i_data[i*BW_DATA +: BW_DATA] : w_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_tag   <= '0;
      r_data  <= '0;
      r_src   <= '0;
      r_ptr   <= '0;
`ifdef CDB_ARB_SPEC_SQUASH_EN
      r_spec  <= 1'b0;
`endif
    end else if (w_load) begin
      r_valid <= w_found;
      if (w_found) begin
        r_tag  <= w_tag;
        r_data <= w_data;
        r_src  <= w_grant;
        r_ptr  <= (w_gidx == PW'(N-1)) ? '0 : w_gidx + 1'b1;
`ifdef CDB_ARB_SPEC_SQUASH_EN
        // A branch resolving this cycle leaves the captured entry non-speculative.
        r_spec <= |(i_spec & w_grant) && !i_branch_valid;
`endif
      end
    end
`ifdef CDB_ARB_SPEC_SQUASH_EN
    else if (w_flush && r_spec) r_valid <= 1'b0;
    else if (i_branch_valid) r_spec <= 1'b0;
`endif
  end
endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: directed stimulus with a queue scoreboard checked by a CDB monitor.
module tb_cdb_arbiter;
  localparam int N = 4, BT = 6, BD = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [N-1:0]  i_valid, i_ready, i_spec, o_src;
  logic [N*BT-1:0] i_tag;
  logic [N*BD-1:0] i_data;
  logic          o_valid, o_ready, i_branch_valid, i_branch_correct_prediction;
  logic [BT-1:0] o_tag;
  logic [BD-1:0] o_data;

  int n_pass = 0, n_tot = 0;
  logic [BT+BD+N-1:0] q[$];

  cdb_arbiter #(.N(N), .BW_TAG(BT), .BW_DATA(BD)) dut (
    .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .i_ready(i_ready),
    .i_tag(i_tag), .i_data(i_data), .i_spec(i_spec), .o_valid(o_valid),
    .o_ready(o_ready), .o_tag(o_tag), .o_data(o_data), .o_src(o_src),
    .i_branch_valid(i_branch_valid),
    .i_branch_correct_prediction(i_branch_correct_prediction)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic put(input int k, input logic [BT-1:0] t, input logic [BD-1:0] d);
    i_tag[k*BT +: BT] = t;
    i_data[k*BD +: BD] = d;
  endtask

  task automatic push(input logic [BT-1:0] t, input logic [BD-1:0] d, input logic [N-1:0] s);
    q.push_back({t, d, s});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (rst_n && o_valid && o_ready) begin
      if (q.size() == 0) begin
        n_tot++;
        $display("FAIL cdb_unexpected: got tag %0h src %b with nothing expected", o_tag, o_src);
      end else chk("cdb_result", {o_tag, o_data, o_src}, q.pop_front());
    end
  end

  initial begin
    rst_n = 1'b0; i_valid = '0; i_spec = '0; i_tag = '0; i_data = '0; o_ready = 1'b0;
    i_branch_valid = 1'b0; i_branch_correct_prediction = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_valid", o_valid, 0);
    chk("rst_tag", o_tag, 0);
    chk("rst_data", o_data, 0);
    chk("rst_src", o_src, 0);
    tick();
    // Full rotation with every unit requesting
    i_valid = 4'hf; o_ready = 1'b1;
    for (int k = 0; k < N; k++) put(k, BT'(6'h10 + k), 32'hA000_0000 + k);
    for (int c = 0; c < 5; c++) begin
      push(BT'(6'h10 + c % 4), 32'hA000_0000 + c % 4, 4'b1 << (c % 4));
      @(negedge clk);
      chk("rr_grant", i_ready, 4'b1 << (c % 4));
      tick();
    end
    i_valid = '0;
    tick();
    // Back-pressure hold, ptr=1 so unit 2 wins
    i_valid = 4'b0100; o_ready = 1'b0;
    put(2, 6'h15, 32'hDEADBEEF);
    push(6'h15, 32'hDEADBEEF, 4'b0100);
    @(negedge clk);
    chk("hold_grant", i_ready, 4'b0100);
    tick();
    i_valid = 4'b0001;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("hold_valid", o_valid, 1);
      chk("hold_tag", o_tag, 6'h15);
      chk("hold_data", o_data, 32'hDEADBEEF);
      chk("hold_ready", i_ready, 0);
      tick();
    end
    // Handshake completes; ptr=3 with only unit 1 requesting wraps
    o_ready = 1'b1; i_valid = 4'b0010;
    put(1, 6'h21, 32'h1111_1111);
    push(6'h21, 32'h1111_1111, 4'b0010);
    @(negedge clk);
    chk("wrap_grant", i_ready, 4'b0010);
    tick();
    i_valid = 4'hf;
    put(2, 6'h22, 32'h2222_2222);
    push(6'h22, 32'h2222_2222, 4'b0100);
    @(negedge clk);
    chk("ptr_after_wrap", i_ready, 4'b0100);
    tick();
    i_valid = '0;
    tick();
`ifdef CDB_ARB_SPEC_SQUASH_EN
    // Speculative entry held, then squashed while unit 0 refills
    i_valid = 4'b1000; i_spec = 4'b1000; o_ready = 1'b0;
    put(3, 6'h33, 32'h3333_3333);
    @(negedge clk);
    chk("spec_grant", i_ready, 4'b1000);
    tick();
    i_valid = '0; i_spec = '0;
    @(negedge clk);
    chk("spec_held", o_valid, 1);
    tick();
    i_branch_valid = 1'b1; i_branch_correct_prediction = 1'b0; i_valid = 4'b0001;
    put(0, 6'h30, 32'h3030_3030);
    push(6'h30, 32'h3030_3030, 4'b0001);
    @(negedge clk);
    chk("flush_drop", o_valid, 0);
    chk("flush_refill", i_ready, 4'b0001);
    tick();
    i_branch_valid = 1'b0; i_valid = '0;
    @(negedge clk);
    chk("refill_valid", o_valid, 1);
    chk("refill_src", o_src, 4'b0001);
    tick();
    o_ready = 1'b1;
    tick();
    // Correct resolution in the grant cycle clears speculation
    i_valid = 4'b0010; i_spec = 4'b0010; i_branch_valid = 1'b1; i_branch_correct_prediction = 1'b1;
    put(1, 6'h31, 32'h3131_3131);
    push(6'h31, 32'h3131_3131, 4'b0010);
    @(negedge clk);
    chk("resolved_grant", i_ready, 4'b0010);
    tick();
    i_valid = '0; i_spec = '0; i_branch_correct_prediction = 1'b0;
    @(negedge clk);
    chk("no_squash", o_valid, 1);
    tick();
    i_branch_valid = 1'b0;
`else
    // Speculation inputs are ignored in this build
    i_valid = 4'b0010; i_spec = 4'b0010; i_branch_valid = 1'b1; i_branch_correct_prediction = 1'b0;
    put(1, 6'h31, 32'h3131_3131);
    push(6'h31, 32'h3131_3131, 4'b0010);
    @(negedge clk);
    chk("nospec_grant", i_ready, 4'b0010);
    tick();
    i_valid = '0; i_spec = '0;
    @(negedge clk);
    chk("nospec_valid", o_valid, 1);
    tick();
    i_branch_valid = 1'b0;
`endif
    // Asynchronous reset while a result is held
    i_valid = 4'b0001; o_ready = 1'b0;
    put(0, 6'h3f, 32'h5555_AAAA);
    tick();
    i_valid = '0;
    @(negedge clk);
    chk("held_pre_rst", o_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_valid", o_valid, 0);
    chk("async_rst_src", o_src, 0);
    chk("async_rst_tag", o_tag, 0);
    tick();
    rst_n = 1'b1; o_ready = 1'b1; i_valid = 4'hf;
    for (int k = 0; k < N; k++) put(k, BT'(6'h20 + k), 32'hB000_0000 + k);
    push(6'h20, 32'hB000_0000, 4'b0001);
    @(negedge clk);
    chk("ptr_reset", i_ready, 4'b0001);
    tick();
    i_valid = '0;
    tick();
    @(negedge clk);
    chk("drain", q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
